// File: rtl/imem_boot_loader.sv
// imem_boot_loader: assembles a host byte stream into instruction words and
// writes them to the IMEM write port from address 0. The cpu is held in reset
// until the whole image has been written.
//
// Stream: 16-bit word count N (MSB first), then N words of DATA_WIDTH/8 bytes
// each (MSB first), then, with BOOT_CHECKSUM_EN defined, one checksum byte
// equal to the XOR of every preceding byte.
//
// Optional feature macro: BOOT_CHECKSUM_EN (undefined = no checksum stage).
//
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   s_valid/s_data      byte source (transfer = s_valid & s_ready)
//   s_ready             loader can accept a byte
//   imem_we/addr/wdata  IMEM write port, one strobe per assembled word
//   cpu_reset           held high until one cycle after done rises
//   done, error         sticky load status, cleared only by reset
//   words_loaded        number of words written so far
module imem_boot_loader #(
    parameter int unsigned WIDTH      = 12,
    parameter int unsigned DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  s_valid,
    input  logic [7:0]            s_data,
    output logic                  s_ready,
    output logic                  imem_we,
    output logic [WIDTH-1:0]      imem_addr,
    output logic [DATA_WIDTH-1:0] imem_wdata,
    output logic                  cpu_reset,
    output logic                  done,
    output logic                  error,
    output logic [WIDTH:0]        words_loaded
);

    localparam int unsigned BPW = DATA_WIDTH / 8;
    localparam int unsigned BCW = (BPW > 1) ? $clog2(BPW) : 1;
    localparam logic [32:0] MAX_WORDS = 33'(1) << WIDTH;

    localparam logic [2:0] S_HDR_HI = 3'd0;
    localparam logic [2:0] S_HDR_LO = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_DONE   = 3'd3;
    localparam logic [2:0] S_ERROR  = 3'd4;
`ifdef BOOT_CHECKSUM_EN
    localparam logic [2:0] S_CSUM   = 3'd5;
`endif

    logic [2:0]            state_q, state_d;
    logic [7:0]            hdr_hi_q, hdr_hi_d;
    logic [WIDTH:0]        n_q, n_d;
    logic [BCW-1:0]        byte_cnt_q, byte_cnt_d;
    logic [DATA_WIDTH-1:0] wbuf_q, wbuf_d;
    logic                  s_ready_q, s_ready_d;
    logic                  imem_we_q, imem_we_d;
    logic [WIDTH-1:0]      imem_addr_q, imem_addr_d;
    logic [DATA_WIDTH-1:0] imem_wdata_q, imem_wdata_d;
    logic                  cpu_reset_q, cpu_reset_d;
    logic                  done_q, done_d;
    logic                  error_q, error_d;
    logic [WIDTH:0]        words_loaded_q, words_loaded_d;
`ifdef BOOT_CHECKSUM_EN
    logic [7:0]            csum_q, csum_d;
`endif

    logic                  xfer;
    logic                  finish;
    logic [15:0]           hdr_n;
    logic [DATA_WIDTH-1:0] wbuf_shift;

    // Next-state and output computation
    always_comb begin
        xfer       = s_valid & s_ready_q;
        hdr_n      = {hdr_hi_q, s_data};
        wbuf_shift = DATA_WIDTH'({wbuf_q, s_data});
        finish     = 1'b0;

        state_d        = state_q;
        hdr_hi_d       = hdr_hi_q;
        n_d            = n_q;
        byte_cnt_d     = byte_cnt_q;
        wbuf_d         = wbuf_q;
        imem_we_d      = 1'b0;
        imem_addr_d    = imem_addr_q;
        imem_wdata_d   = imem_wdata_q;
        done_d         = done_q;
        error_d        = error_q;
        words_loaded_d = words_loaded_q;
        // Release the cpu one cycle after done so the final write lands first
        cpu_reset_d    = ~done_q;
`ifdef BOOT_CHECKSUM_EN
        csum_d         = csum_q;
`endif

        case (state_q)
            S_HDR_HI: begin
                if (xfer) begin
                    hdr_hi_d = s_data;
                    state_d  = S_HDR_LO;
                end
            end
            S_HDR_LO: begin
                if (xfer) begin
                    n_d = (WIDTH+1)'(hdr_n);
                    if (33'(hdr_n) > MAX_WORDS) begin
                        state_d = S_ERROR;
                        error_d = 1'b1;
                    end else if (hdr_n == 16'd0) begin
                        finish = 1'b1;
                    end else begin
                        state_d = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (xfer) begin
                    wbuf_d     = wbuf_shift;
                    byte_cnt_d = byte_cnt_q + BCW'(1);
                    if (byte_cnt_q == BCW'(BPW - 1)) begin
                        byte_cnt_d     = '0;
                        imem_we_d      = 1'b1;
                        imem_addr_d    = WIDTH'(words_loaded_q);
                        imem_wdata_d   = wbuf_shift;
                        words_loaded_d = words_loaded_q + (WIDTH+1)'(1);
                        if (words_loaded_d == n_q) begin
                            finish = 1'b1;
                        end
                    end
                end
            end
`ifdef BOOT_CHECKSUM_EN
            S_CSUM: begin
                if (xfer) begin
                    if (s_data == csum_q) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = S_ERROR;
                        error_d = 1'b1;
                    end
                end
            end
`endif
            default: begin
            end
        endcase

        // Header or last word complete
        if (finish) begin
`ifdef BOOT_CHECKSUM_EN
            state_d = S_CSUM;
`else
            state_d = S_DONE;
            done_d  = 1'b1;
`endif
        end

`ifdef BOOT_CHECKSUM_EN
        // Running XOR over header and data bytes only
        if (xfer && (state_q != S_CSUM)) begin
            csum_d = csum_q ^ s_data;
        end
`endif

        s_ready_d = (state_d != S_DONE) && (state_d != S_ERROR);
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= S_HDR_HI;
            hdr_hi_q       <= '0;
            n_q            <= '0;
            byte_cnt_q     <= '0;
            wbuf_q         <= '0;
            s_ready_q      <= 1'b0;
            imem_we_q      <= 1'b0;
            imem_addr_q    <= '0;
            imem_wdata_q   <= '0;
            cpu_reset_q    <= 1'b1;
            done_q         <= 1'b0;
            error_q        <= 1'b0;
            words_loaded_q <= '0;
`ifdef BOOT_CHECKSUM_EN
            csum_q         <= '0;
`endif
        end else begin
            state_q        <= state_d;
            hdr_hi_q       <= hdr_hi_d;
            n_q            <= n_d;
            byte_cnt_q     <= byte_cnt_d;
            wbuf_q         <= wbuf_d;
            s_ready_q      <= s_ready_d;
            imem_we_q      <= imem_we_d;
            imem_addr_q    <= imem_addr_d;
            imem_wdata_q   <= imem_wdata_d;
            cpu_reset_q    <= cpu_reset_d;
            done_q         <= done_d;
            error_q        <= error_d;
            words_loaded_q <= words_loaded_d;
`ifdef BOOT_CHECKSUM_EN
            csum_q         <= csum_d;
`endif
        end
    end

    assign s_ready      = s_ready_q;
    assign imem_we      = imem_we_q;
    assign imem_addr    = imem_addr_q;
    assign imem_wdata   = imem_wdata_q;
    assign cpu_reset    = cpu_reset_q;
    assign done         = done_q;
    assign error        = error_q;
    assign words_loaded = words_loaded_q;

endmodule
